// File: rtl/pq_fifo_sieve_reader.sv
// ---------------------------------------------------------------------------
// pq_fifo_sieve_reader
//
// Consumer side of the p/q candidate FIFO. Pops one odd candidate at a time,
// runs a bit-serial small-prime sieve (3, 5, 7) over it MSB first, rejects
// even / zero / small-factor / duplicate values, and pairs the survivors into
// (p, q) for the downstream RSA key-setup logic.
//
// Ports:
//   aclk, areset    clock, synchronous active-high reset
//   pq_fifo_rd_en   one-cycle read strobe to a standard (non-FWFT) FIFO
//   pq_fifo_dout    FIFO read data, valid the cycle after pq_fifo_rd_en
//   pq_fifo_empty   FIFO empty flag, only looked at in IDLE
//   p_out, q_out    accepted candidate pair
//   pq_valid        p_out/q_out hold a valid pair (held until pq_ready)
//   pq_ready        downstream accepts the pair
//   reject_cnt      saturating count of rejected candidates
//   o_busy          high in every state except IDLE
// ---------------------------------------------------------------------------
module pq_fifo_sieve_reader #(
    parameter int NUM_BITS = 128,
    parameter int CNT_BITS = 16
) (
    input  logic                aclk,
    input  logic                areset,
    output logic                pq_fifo_rd_en,
    input  logic [NUM_BITS-1:0] pq_fifo_dout,
    input  logic                pq_fifo_empty,
    output logic [NUM_BITS-1:0] p_out,
    output logic [NUM_BITS-1:0] q_out,
    output logic                pq_valid,
    input  logic                pq_ready,
    output logic [CNT_BITS-1:0] reject_cnt,
    output logic                o_busy
);

    localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_SIEVE   = 3'd3,
        S_CHECK   = 3'd4,
        S_OUTPUT  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [NUM_BITS-1:0] r_cand;
    logic [NUM_BITS-1:0] r_p;
    logic [NUM_BITS-1:0] r_q;
    logic                r_p_full;
    logic [CNT_BITS-1:0] r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [2:0]          r_r3;
    logic [2:0]          r_r5;
    logic [2:0]          r_r7;

    logic                w_bit;
    logic                w_reject;

    // One step of (2*r + b) mod m. Since r < m, 2r+b <= 2m-1, so a single
    // conditional subtract is enough: no divider is inferred.
    function automatic logic [2:0] f_mod_step(input logic [2:0] r,
                                              input logic       b,
                                              input logic [3:0] m);
        logic [3:0] t;
        t = {r, b};
        if (t >= m)
            t = t - m;
        return t[2:0];
    endfunction

    assign w_bit = r_cand[r_idx];

    // A candidate that reaches zero remainder for 3, 5 or 7 has that factor.
    // The duplicate test only matters once p is already held.
    assign w_reject = !r_cand[0]
                   || (r_cand == '0)
                   || (r_r3 == 3'd0)
                   || (r_r5 == 3'd0)
                   || (r_r7 == 3'd0)
                   || (r_p_full && (r_cand == r_p));

    // ---------------- state register ----------------
    always_ff @(posedge aclk) begin
        if (areset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (!pq_fifo_empty) w_next = S_READ;
            S_READ:    w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_SIEVE;
            S_SIEVE:   if (r_idx == '0) w_next = S_CHECK;
            S_CHECK:   w_next = (!w_reject && r_p_full) ? S_OUTPUT : S_IDLE;
            S_OUTPUT:  if (pq_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        pq_fifo_rd_en = 1'b0;
        pq_valid      = 1'b0;
        o_busy        = 1'b1;
        case (r_state)
            S_IDLE:   o_busy        = 1'b0;
            S_READ:   pq_fifo_rd_en = 1'b1;
            S_OUTPUT: pq_valid      = 1'b1;
            default:  ;
        endcase
    end

    assign p_out      = r_p;
    assign q_out      = r_q;
    assign reject_cnt = r_cnt;

    // ---------------- datapath ----------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cand   <= '0;
            r_p      <= '0;
            r_q      <= '0;
            r_p_full <= 1'b0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_r3     <= '0;
            r_r5     <= '0;
            r_r7     <= '0;
        end else begin
            case (r_state)
                S_CAPTURE: begin
                    r_cand <= pq_fifo_dout;
                    r_idx  <= IDX_W'(NUM_BITS - 1);
                    r_r3   <= '0;
                    r_r5   <= '0;
                    r_r7   <= '0;
                end
                S_SIEVE: begin
                    r_r3  <= f_mod_step(r_r3, w_bit, 4'd3);
                    r_r5  <= f_mod_step(r_r5, w_bit, 4'd5);
                    r_r7  <= f_mod_step(r_r7, w_bit, 4'd7);
                    r_idx <= r_idx - 1'b1;
                end
                S_CHECK: begin
                    if (w_reject) begin
                        if (r_cnt != '1)
                            r_cnt <= r_cnt + 1'b1;
                    end else if (!r_p_full) begin
                        r_p      <= r_cand;
                        r_p_full <= 1'b1;
                    end else begin
                        r_q <= r_cand;
                    end
                end
                S_OUTPUT: begin
                    if (pq_ready)
                        r_p_full <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
